// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift engine: operation encoding,
// FSM state encoding and a step-count helper.
package shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t SH_SLL  = 3'b000;
    localparam mode_t SH_SRL  = 3'b001;
    localparam mode_t SH_SRA  = 3'b010;
    localparam mode_t SH_ROL  = 3'b011;
    localparam mode_t SH_ROR  = 3'b100;
    localparam mode_t SH_SLI  = 3'b101;
    localparam mode_t SH_SRI  = 3'b110;
    localparam mode_t SH_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of BUSY cycles needed to shift by amt at up to step bits per cycle.
    function automatic int unsigned step_count(input int unsigned amt, input int unsigned step);
        return (amt + step - 1) / step;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational single step of the shift engine: shifts by k (0..STEP) for the
// given mode and returns the word, the last bit out and the OR of discarded bits.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 4,
    localparam int KW    = $clog2(STEP + 1),
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  mode_t            mode,
    input  logic             fill,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             sticky
);

    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    logic [IW-1:0]    left_idx;
    logic [IW-1:0]    right_idx;
    logic             right_fill;

    assign lo_mask   = ~({WIDTH{1'b1}} << k);
    assign hi_mask   = ~({WIDTH{1'b1}} >> k);
    // k is never 0 where these indices are used, so WIDTH-k and k-1 both fit IW bits.
    assign left_idx  = IW'(WIDTH - int'(k));
    assign right_idx = IW'(int'(k) - 1);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res        = data;
        carry      = 1'b0;
        sticky     = 1'b0;
        right_fill = 1'b0;
        if (k != '0) begin
            case (mode)
                SH_SLL, SH_SLI: begin
                    res    = (data << k) | ((mode == SH_SLI && fill) ? lo_mask : '0);
                    carry  = data[left_idx];
                    sticky = |(data & hi_mask);
                end
                SH_SRL, SH_SRA, SH_SRI: begin
                    if (mode == SH_SRA)      right_fill = data[WIDTH-1];
                    else if (mode == SH_SRI) right_fill = fill;
                    res    = (data >> k) | (right_fill ? hi_mask : '0);
                    carry  = data[right_idx];
                    sticky = |(data & lo_mask);
                end
                SH_ROL: begin
                    res   = (data << k) | (data >> left_idx);
                    carry = res[0];
                end
                SH_ROR: begin
                    res   = (data >> k) | (data << left_idx);
                    carry = res[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/univ_shift_engine.sv
// Multi-cycle universal shifter: accepts one operand per handshake, shifts it
// by up to STEP bits per cycle and presents the result with carry/sticky flags.
module univ_shift_engine
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_mode,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_sticky,
    output logic             busy
);

    localparam int            KW      = $clog2(STEP + 1);
    localparam logic [AW:0]   MAX_AMT = WIDTH[AW:0] - 1'b1;

    state_t           state_q, state_d;
    logic [AW-1:0]    rem_q;
    logic [AW-1:0]    eff_amt;
    mode_t            mode_q;
    logic             fill_q;
    logic [WIDTH-1:0] data_q;
    logic             carry_q, sticky_q;
    logic [WIDTH-1:0] stage_res;
    logic             stage_carry, stage_sticky;
    logic [KW-1:0]    k;
    logic             accept;
    state_t           start_state;

    // PASS ignores the amount; codes beyond WIDTH-1 (non-power-of-2 WIDTH) saturate.
    always_comb begin
        if (in_mode == SH_PASS)             eff_amt = '0;
        else if ({1'b0, in_amt} > MAX_AMT)  eff_amt = MAX_AMT[AW-1:0];
        else                                eff_amt = in_amt;
    end

    always_comb begin
        if (int'(rem_q) > STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
    end

    assign start_state = (eff_amt == '0) ? ST_DONE : ST_BUSY;
    assign accept      = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = start_state;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (int'(rem_q) <= STEP) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? start_state : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    shift_stage #(.WIDTH(WIDTH), .STEP(STEP)) u_stage (
        .data   (data_q),
        .k      (k),
        .mode   (mode_q),
        .fill   (fill_q),
        .res    (stage_res),
        .carry  (stage_carry),
        .sticky (stage_sticky)
    );

    // NOTE: the working word doubles as the output register, so it is reset too:
    // out_data and the flags must read 0 the moment rstn falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q   <= '0;
            rem_q    <= '0;
            mode_q   <= SH_SLL;
            fill_q   <= 1'b0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (accept) begin
            data_q   <= in_data;
            rem_q    <= eff_amt;
            mode_q   <= in_mode;
            fill_q   <= ser_in;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            data_q   <= stage_res;
            rem_q    <= rem_q - AW'(k);
            carry_q  <= stage_carry;
            sticky_q <= sticky_q | stage_sticky;
        end
    end

    assign out_data   = data_q;
    assign out_carry  = carry_q;
    assign out_sticky = sticky_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Self-checking bench for univ_shift_engine (WIDTH=16, STEP=4): directed vectors,
// backpressure, reset mid-operation and randomized ops against a whole-amount model.
module tb_univ_shift_engine;
    import shift_pkg::*;

    localparam int WIDTH = 16;
    localparam int STEP  = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [2:0]  in_mode;
    logic        ser_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_sticky;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    univ_shift_engine #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_mode    (in_mode),
        .ser_in     (ser_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_carry  (out_carry),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        sticky;
        int          lat;
    } exp_t;

    // Whole-amount reference: the result of shifting by the full amount at once.
    function automatic exp_t ref_model(input logic [15:0] d, input int amt,
                                       input logic [2:0] mode, input logic ser);
        exp_t        e;
        logic [31:0] wide;
        logic [15:0] ones;
        int          a;
        ones     = '1;
        a        = (mode == SH_PASS) ? 0 : amt;
        e.data   = d;
        e.carry  = 1'b0;
        e.sticky = 1'b0;
        if (a > 0) begin
            case (mode)
                SH_SLL, SH_SLI: begin
                    wide     = {16'h0000, d} << a;
                    e.data   = wide[15:0];
                    e.carry  = wide[16];
                    e.sticky = |wide[31:16];
                    if (mode == SH_SLI && ser) e.data = e.data | ~(ones << a);
                end
                SH_SRL, SH_SRA, SH_SRI: begin
                    wide     = {d, 16'h0000} >> a;
                    e.data   = wide[31:16];
                    e.carry  = wide[15];
                    e.sticky = |wide[15:0];
                    if ((mode == SH_SRA && d[15]) || (mode == SH_SRI && ser))
                        e.data = e.data | ~(ones >> a);
                end
                SH_ROL: begin
                    e.data  = (d << a) | (d >> (16 - a));
                    e.carry = e.data[0];
                end
                SH_ROR: begin
                    e.data  = (d >> a) | (d << (16 - a));
                    e.carry = e.data[15];
                end
                default: ;
            endcase
        end
        e.lat = 1 + (a + STEP - 1) / STEP;
        return e;
    endfunction

    // Issue one op (back-to-back if a result is pending), wait for its result,
    // then hold it under backpressure for `hold` cycles with a competing in_valid.
    task automatic do_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                         input logic [2:0] m, input logic s, input int hold);
        exp_t e;
        int   lat;
        int   busy_cyc;
        e        = ref_model(d, int'(a), m, s);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        ser_in   = s;
        in_valid = 1'b1;
        if (out_valid) out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'($urandom);
        in_amt    = 4'($urandom);
        in_mode   = 3'($urandom);
        ser_in    = ~s;
        lat       = 1;
        busy_cyc  = 0;
        while (!out_valid && lat < 40) begin
            busy_cyc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".latency"},   32'(lat),       32'(e.lat));
        check({tag, ".busy_cyc"},  32'(busy_cyc),  32'(e.lat - 1));
        check({tag, ".data"},      32'(out_data),  32'(e.data));
        check({tag, ".carry"},     32'(out_carry), 32'(e.carry));
        check({tag, ".sticky"},    32'(out_sticky), 32'(e.sticky));
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"},  32'(out_valid), 32'd1);
            check({tag, ".hold_ready"},  32'(in_ready),  32'd0);
            check({tag, ".hold_data"},   32'(out_data),  32'(e.data));
            check({tag, ".hold_flags"},  32'({out_carry, out_sticky}), 32'({e.carry, e.sticky}));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = SH_SLL;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.flags",     32'({out_carry, out_sticky}), 32'd0);
        #19 rstn = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, chained back-to-back where a result is pending.
        do_op("sll", 16'h8001, 4'd1, SH_SLL, 1'b0, 0);
        check("sll.lit", 32'({out_data, out_carry, out_sticky}), 32'({16'h0002, 1'b1, 1'b1}));
        do_op("sra", 16'h8000, 4'd15, SH_SRA, 1'b0, 0);
        check("sra.lit", 32'({out_data, out_carry, out_sticky}), 32'({16'hFFFF, 1'b0, 1'b0}));
        do_op("ror", 16'h1234, 4'd4, SH_ROR, 1'b0, 0);
        check("ror.lit", 32'({out_data, out_carry, out_sticky}), 32'({16'h4123, 1'b0, 1'b0}));
        do_op("rol", 16'h1234, 4'd4, SH_ROL, 1'b0, 0);
        check("rol.lit", 32'(out_data), 32'h2341);
        do_op("sri", 16'h0000, 4'd3, SH_SRI, 1'b1, 0);
        check("sri.lit", 32'(out_data), 32'hE000);
        do_op("pass", 16'hBEEF, 4'd9, SH_PASS, 1'b0, 3);
        check("pass.lit", 32'({out_data, out_carry, out_sticky}), 32'({16'hBEEF, 1'b0, 1'b0}));
        do_op("b2b", 16'h00FF, 4'd8, SH_SLL, 1'b0, 0);
        check("b2b.lit", 32'(out_data), 32'hFF00);
        drain("b2b");

        // Reset in the middle of a 3-step SLL.
        in_data  = 16'hFFFF;
        in_amt   = 4'd12;
        in_mode  = SH_SLL;
        ser_in   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid.busy", 32'(busy), 32'd1);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.busy_rst",  32'(busy),      32'd0);
        check("mid.out_data",  32'(out_data),  32'd0);
        check("mid.flags",     32'({out_carry, out_sticky}), 32'd0);
        #8 rstn = 1'b1;
        @(posedge clk); #1;
        check("mid.in_ready", 32'(in_ready),  32'd1);
        check("mid.idle",     32'(out_valid), 32'd0);
        do_op("after_rst", 16'hA5C3, 4'd12, SH_SLL, 1'b0, 0);
        drain("after_rst");

        // Randomized ops, mixing back-to-back issue, idle gaps and backpressure.
        for (int n = 0; n < 80; n++) begin
            do_op($sformatf("rand%0d", n), 16'($urandom), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                drain($sformatf("rand%0d", n));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (out_valid) drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
